// File: rtl/fe_test_pkg.sv
// rtl/fe_test_pkg.sv - shared encodings and constants for the front-end test pattern checker
package fe_test_pkg;

  localparam logic [1:0] FE_MODE_BYPASS = 2'd0;
  localparam logic [1:0] FE_MODE_DCPOS  = 2'd1;
  localparam logic [1:0] FE_MODE_DCNEG  = 2'd2;
  localparam logic [1:0] FE_MODE_TRI    = 2'd3;

  localparam logic [23:0] DC_POS = 24'h7fff00;
  localparam logic [23:0] DC_NEG = 24'h8000ff;

  localparam int INC_SHIFT = 13;

  // mclk cycles per sample strobe for the supported SmpRate settings
  localparam int SMP_DIV_48K  = 1115;
  localparam int SMP_DIV_96K  = 557;
  localparam int SMP_DIV_192K = 279;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_CHECK   = 2'd2
  } fe_state_t;

  function automatic logic [23:0] tri_step(input logic [7:0] inc);
    return 24'(inc) << INC_SHIFT;
  endfunction

endpackage

// File: rtl/fe_period_meter.sv
// rtl/fe_period_meter.sv - clocks between consecutive sample strobes
module fe_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  output logic [CNT_W-1:0] period_clks
);

  logic [CNT_W-1:0] gap_cnt;
  logic             seen;

  // gap_cnt counts clocks since the last strobe, so the interval is gap_cnt + 1
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt     <= '0;
      seen        <= 1'b0;
      period_clks <= '0;
    end else if (strobe) begin
      gap_cnt <= '0;
      seen    <= 1'b1;
      if (seen) begin
        period_clks <= (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
      end
    end else if (gap_cnt != '1) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frontend_test_checker.sv
// rtl/frontend_test_checker.sv - receive-side checker for the front-end test pattern stream
module frontend_test_checker
  import fe_test_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear_stats,
  input  logic [1:0]        check_select,
  input  logic [7:0]        triangle_inc_reg,
  input  logic              fe_valid,
  input  logic [DATA_W-1:0] l_fe_data,
  input  logic [DATA_W-1:0] r_fe_data,
  output logic              locked,
  output logic [CNT_W-1:0]  error_count,
  output logic [DATA_W-1:0] first_err_data,
  output logic [23:0]       sample_count,
  output logic [CNT_W-1:0]  period_clks,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [CNT_W-1:0]  reversal_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]  LOCK_RUN      = RUN_W'(LOCK_COUNT);
  localparam logic [DATA_W-1:0] PEAK_MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] PEAK_MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};

  fe_state_t         state, state_nxt;
  logic              clr;
  logic [1:0]        mode_q;
  logic [7:0]        inc_q;
  logic              cfg_change;
  logic              smp_valid, acq_smp, chk_smp;
  logic [DATA_W-1:0] prev_q;
  logic              dir_q, dir_known;
  logic [RUN_W-1:0]  good_run, run_inc;
  logic [DATA_W-1:0] step, step_neg, delta;
  logic              step_ok, dir_new, lr_diff, smp_bad, rev_event;
  logic [DATA_W-1:0] lr_max, lr_min;

  assign clr        = reset | ~run;
  assign cfg_change = (check_select != mode_q) || (triangle_inc_reg != inc_q);
  assign smp_valid  = fe_valid && (state != ST_IDLE);
  // a config change re-acquires, so a strobe in that cycle is taken as the new reference
  assign acq_smp    = smp_valid && ((state == ST_ACQUIRE) || cfg_change);
  assign chk_smp    = smp_valid && (state == ST_CHECK) && !cfg_change;

  assign step     = DATA_W'(tri_step(triangle_inc_reg));
  assign step_neg = -step;
  assign delta    = l_fe_data - prev_q;
  // a zero step would match a flat signal, which is never a valid triangle
  assign step_ok  = (step != '0) && ((delta == step) || (delta == step_neg));
  assign dir_new  = (delta == step);
  assign lr_diff  = (l_fe_data != r_fe_data);
  assign run_inc  = (good_run == LOCK_RUN) ? good_run : good_run + 1'b1;
  assign rev_event = (check_select == FE_MODE_TRI) && step_ok && dir_known && (dir_new != dir_q);

  assign lr_max = ($signed(l_fe_data) > $signed(r_fe_data)) ? l_fe_data : r_fe_data;
  assign lr_min = ($signed(l_fe_data) < $signed(r_fe_data)) ? l_fe_data : r_fe_data;

  always_comb begin
    smp_bad = 1'b0;
    case (check_select)
      FE_MODE_DCPOS: smp_bad = lr_diff || (l_fe_data != DATA_W'(DC_POS));
      FE_MODE_DCNEG: smp_bad = lr_diff || (l_fe_data != DATA_W'(DC_NEG));
      FE_MODE_TRI:   smp_bad = lr_diff || !step_ok;
      default:       smp_bad = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_ACQUIRE;
      ST_ACQUIRE, ST_CHECK: begin
        if (acq_smp) begin
          state_nxt = ST_CHECK;
        end else if (cfg_change) begin
          state_nxt = ST_ACQUIRE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= ST_IDLE;
      mode_q         <= '0;
      inc_q          <= '0;
      prev_q         <= '0;
      dir_q          <= 1'b0;
      dir_known      <= 1'b0;
      good_run       <= '0;
      locked         <= 1'b0;
      error_count    <= '0;
      first_err_data <= '0;
      sample_count   <= '0;
      reversal_count <= '0;
      peak_max       <= PEAK_MAX_INIT;
      peak_min       <= PEAK_MIN_INIT;
    end else begin
      state  <= state_nxt;
      mode_q <= check_select;
      inc_q  <= triangle_inc_reg;

      if (cfg_change) begin
        good_run <= '0;
        locked   <= 1'b0;
      end

      if (acq_smp) begin
        prev_q    <= l_fe_data;
        dir_known <= 1'b0;
      end

      if (chk_smp) begin
        prev_q <= l_fe_data;
        if ((check_select == FE_MODE_TRI) && step_ok) begin
          dir_q     <= dir_new;
          dir_known <= 1'b1;
        end
        if (smp_bad) begin
          good_run <= '0;
          locked   <= 1'b0;
        end else if (check_select != FE_MODE_BYPASS) begin
          good_run <= run_inc;
          locked   <= (run_inc == LOCK_RUN);
        end
      end

      // statistics: a same-cycle clear beats the sample's contribution
      if (clear_stats) begin
        error_count    <= '0;
        first_err_data <= '0;
        sample_count   <= '0;
        reversal_count <= '0;
        peak_max       <= PEAK_MAX_INIT;
        peak_min       <= PEAK_MIN_INIT;
      end else begin
        if (smp_valid) begin
          sample_count <= sample_count + 1'b1;
          if ($signed(lr_max) > $signed(peak_max)) peak_max <= lr_max;
          if ($signed(lr_min) < $signed(peak_min)) peak_min <= lr_min;
        end
        if (chk_smp && smp_bad) begin
          if (error_count == '0) first_err_data <= l_fe_data;
          if (error_count != '1) error_count <= error_count + 1'b1;
        end
        if (chk_smp && rev_event && (reversal_count != '1)) begin
          reversal_count <= reversal_count + 1'b1;
        end
      end
    end
  end

  fe_period_meter #(
    .CNT_W (CNT_W)
  ) u_period (
    .clk         (clk),
    .reset       (clr),
    .strobe      (smp_valid),
    .period_clks (period_clks)
  );

endmodule

// File: tb/tb_frontend_test_checker.sv
// tb/tb_frontend_test_checker.sv - scoreboard bench for frontend_test_checker
module tb_frontend_test_checker;
  import fe_test_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, clear_stats, fe_valid;
  logic [1:0]  check_select;
  logic [7:0]  triangle_inc_reg;
  logic [23:0] l_fe_data, r_fe_data;
  logic        locked;
  logic [15:0] error_count, period_clks, reversal_count;
  logic [23:0] first_err_data, sample_count, peak_max, peak_min;

  always #5 clk = ~clk;

  frontend_test_checker dut (
    .clk(clk), .reset(reset), .run(run), .clear_stats(clear_stats),
    .check_select(check_select), .triangle_inc_reg(triangle_inc_reg),
    .fe_valid(fe_valid), .l_fe_data(l_fe_data), .r_fe_data(r_fe_data),
    .locked(locked), .error_count(error_count), .first_err_data(first_err_data),
    .sample_count(sample_count), .period_clks(period_clks), .peak_max(peak_max),
    .peak_min(peak_min), .reversal_count(reversal_count)
  );

  typedef struct {
    logic        locked;
    logic [15:0] err;
    logic [23:0] ferr;
    logic [23:0] scnt;
    logic [15:0] per;
    logic [23:0] pmax;
    logic [23:0] pmin;
    logic [15:0] rev;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;

  // reference model state: phase 0 idle, 1 acquire, 2 check
  exp_t   m;
  int     m_phase, m_mode, m_inc, m_prev, m_run, m_pmax_s, m_pmin_s;
  bit     m_dir, m_dir_known, m_have;
  longint cyc = 0, m_last = 0;

  function automatic int sx(int x);
    return (x >= 32'h800000) ? x - 32'h1000000 : x;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_inc = 0; m_prev = 0; m_run = 0;
    m_dir = 0; m_dir_known = 0; m_have = 0;
    m_pmax_s = -8388608; m_pmin_s = 8388607;
    m.locked = 0; m.err = 0; m.ferr = 0; m.scnt = 0; m.per = 0; m.rev = 0;
    m.pmax = 24'h800000; m.pmin = 24'h7fffff;
  endtask

  task automatic model_clock();
    bit v, acq, chk, cfg, bad, gd, dn, rev_evt;
    int l, r, delta, step;
    cyc++;
    if (reset || !run) begin
      model_reset();
    end else begin
      l = int'(l_fe_data); r = int'(r_fe_data);
      cfg = (int'(check_select) != m_mode) || (int'(triangle_inc_reg) != m_inc);
      m_mode = int'(check_select); m_inc = int'(triangle_inc_reg);
      v   = fe_valid && (m_phase != 0);
      acq = v && ((m_phase == 1) || cfg);
      chk = v && (m_phase == 2) && !cfg;
      if (cfg) begin m_run = 0; m.locked = 0; end
      if (v) begin
        if (m_have) m.per = 16'((cyc - m_last > 65535) ? 65535 : cyc - m_last);
        m_last = cyc; m_have = 1;
      end
      step  = m_inc * 8192;
      delta = (l - m_prev) & 32'hffffff;
      gd    = (step != 0) && ((delta == step) || (delta == ((32'h1000000 - step) & 32'hffffff)));
      dn    = (delta == step);
      case (m_mode)
        1: bad = (l != r) || (l != int'(DC_POS));
        2: bad = (l != r) || (l != int'(DC_NEG));
        3: bad = (l != r) || !gd;
        default: bad = 0;
      endcase
      rev_evt = 0;
      if (acq) begin m_prev = l; m_dir_known = 0; end
      if (chk) begin
        m_prev = l;
        rev_evt = (m_mode == 3) && gd && m_dir_known && (dn != m_dir);
        if (m_mode == 3 && gd) begin m_dir = dn; m_dir_known = 1; end
        if (bad) begin m_run = 0; m.locked = 0; end
        else if (m_mode != 0) begin
          if (m_run < 4) m_run++;
          m.locked = (m_run == 4);
        end
      end
      if (m_phase == 0) m_phase = 1;
      else if (acq) m_phase = 2;
      else if (cfg) m_phase = 1;
      if (clear_stats) begin
        m.err = 0; m.ferr = 0; m.scnt = 0; m.rev = 0;
        m_pmax_s = -8388608; m_pmin_s = 8388607;
      end else begin
        if (v) begin
          m.scnt = m.scnt + 24'd1;
          if (sx(l) > m_pmax_s) m_pmax_s = sx(l);
          if (sx(r) > m_pmax_s) m_pmax_s = sx(r);
          if (sx(l) < m_pmin_s) m_pmin_s = sx(l);
          if (sx(r) < m_pmin_s) m_pmin_s = sx(r);
        end
        if (chk && bad) begin
          if (m.err == 0) m.ferr = l_fe_data;
          if (m.err != 16'hffff) m.err = m.err + 16'd1;
        end
        if (rev_evt && m.rev != 16'hffff) m.rev = m.rev + 16'd1;
      end
      m.pmax = m_pmax_s[23:0]; m.pmin = m_pmin_s[23:0];
    end
    if (fe_valid) exp_q.push_back(m);
  endtask

  task automatic cyc_t();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    fe_valid = 0;
    repeat (n) cyc_t();
  endtask

  task automatic strobe(logic [23:0] l, logic [23:0] r, bit clr);
    fe_valid = 1; l_fe_data = l; r_fe_data = r; clear_stats = clr;
    cyc_t();
    fe_valid = 0; clear_stats = 0;
  endtask

  task automatic send(logic [23:0] l, logic [23:0] r, int gap);
    strobe(l, r, 0);
    if (gap > 1) idle(gap - 1);
  endtask

  // monitor: every strobe's effect is visible at the following falling edge
  initial forever begin
    @(posedge clk);
    if (fe_valid) begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        cmp("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        cmp("locked", 32'(locked), 32'(e.locked));
        cmp("error_count", 32'(error_count), 32'(e.err));
        cmp("first_err_data", 32'(first_err_data), 32'(e.ferr));
        cmp("sample_count", 32'(sample_count), 32'(e.scnt));
        cmp("period_clks", 32'(period_clks), 32'(e.per));
        cmp("peak_max", 32'(peak_max), 32'(e.pmax));
        cmp("peak_min", 32'(peak_min), 32'(e.pmin));
        cmp("reversal_count", 32'(reversal_count), 32'(e.rev));
      end
    end
  end

  logic [23:0] ramp1 [7] = '{24'h0, 24'h2a000, 24'h54000, 24'h7e000, 24'h54000, 24'h2a000, 24'h0};
  logic [23:0] ramp2 [7] = '{24'h2a000, 24'h54001, 24'h7e000, 24'h54000, 24'h2a000, 24'h0, 24'h2a000};

  initial begin
    int tri_v, stp, sel;
    bit up;
    logic [23:0] l, r, flip;
    reset = 1; run = 1; clear_stats = 0; fe_valid = 0;
    check_select = 0; triangle_inc_reg = 0; l_fe_data = 0; r_fe_data = 0;
    model_reset();
    repeat (3) cyc_t();
    cmp("rst_locked", 32'(locked), 0);
    cmp("rst_peak_max", 32'(peak_max), 32'h800000);
    cmp("rst_peak_min", 32'(peak_min), 32'h7fffff);
    cmp("rst_samples", 32'(sample_count), 0);
    reset = 0;

    // DC positive, 48k-style strobe spacing
    check_select = FE_MODE_DCPOS;
    idle(2);
    for (int i = 0; i < 10; i++) begin
      strobe(DC_POS, DC_POS, 0);
      if (i == 3) cmp("m1_lock_4th", 32'(locked), 0);
      if (i == 4) cmp("m1_lock_5th", 32'(locked), 1);
      idle(1114);
    end
    cmp("m1_period", 32'(period_clks), 1115);
    cmp("m1_errors", 32'(error_count), 0);
    cmp("m1_peak_max", 32'(peak_max), 32'h7fff00);
    cmp("m1_peak_min", 32'(peak_min), 32'h7fff00);

    // DC negative with one L/R mismatch
    check_select = FE_MODE_DCNEG;
    idle(3);
    for (int i = 0; i < 12; i++) begin
      send(DC_NEG, (i == 5) ? 24'h8000fe : DC_NEG, 40);
      if (i == 5) cmp("m2_lock_drop", 32'(locked), 0);
    end
    cmp("m2_errors", 32'(error_count), 1);
    cmp("m2_first_err", 32'(first_err_data), 32'h8000ff);
    cmp("m2_relock", 32'(locked), 1);

    // triangle ramp, then one sample off by one
    clear_stats = 1; cyc_t(); clear_stats = 0;
    check_select = FE_MODE_TRI; triangle_inc_reg = 8'h15;
    idle(3);
    for (int i = 0; i < 7; i++) begin
      send(ramp1[i], ramp1[i], 30);
      if (i == 4) cmp("m3_first_reversal", 32'(reversal_count), 1);
    end
    cmp("m3_errors", 32'(error_count), 0);
    cmp("m3_peak_max", 32'(peak_max), 32'h7e000);
    for (int i = 0; i < 7; i++) send(ramp2[i], ramp2[i], 30);
    cmp("m3_err_off1", 32'(error_count), 2);
    cmp("m3_relock", 32'(locked), 1);

    // mode change mid-stream
    check_select = FE_MODE_DCPOS;
    cyc_t();
    cmp("sel_chg_unlock", 32'(locked), 0);
    cmp("sel_chg_err_kept", 32'(error_count), 2);
    for (int i = 0; i < 5; i++) send(DC_POS, DC_POS, 20);
    cmp("sel_chg_relock", 32'(locked), 1);

    // randomized blocks
    for (int b = 0; b < 14; b++) begin
      sel = $urandom_range(0, 3);
      check_select = 2'(sel);
      triangle_inc_reg = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
      stp = int'(triangle_inc_reg) * 8192;
      tri_v = $urandom_range(0, 24'hffffff); up = 1;
      idle(2);
      for (int i = 0; i < 25; i++) begin
        case (sel)
          1: l = DC_POS;
          2: l = DC_NEG;
          3: begin
            if ($urandom_range(0, 4) == 0) up = !up;
            tri_v = (up ? tri_v + stp : tri_v - stp) & 32'hffffff;
            l = tri_v[23:0];
          end
          default: l = 24'($urandom);
        endcase
        r = (sel == 0 && $urandom_range(0, 1) == 0) ? 24'($urandom) : l;
        if ($urandom_range(0, 9) == 0) begin
          flip = 24'h1 << $urandom_range(0, 23);
          case ($urandom_range(0, 2))
            0: begin l = l ^ flip; r = r ^ flip; end
            1: l = l ^ flip;
            default: r = r ^ flip;
          endcase
        end
        strobe(l, r, $urandom_range(0, 19) == 0);
        idle($urandom_range(0, 11));
      end
      if ($urandom_range(0, 2) == 0) begin
        run = 0; idle($urandom_range(1, 3)); run = 1;
      end
    end

    // clear_stats coinciding with a strobe, then a one-clock run drop
    check_select = FE_MODE_DCPOS;
    idle(3);
    for (int i = 0; i < 3; i++) send(DC_POS, DC_POS, 5);
    strobe(DC_POS, DC_POS, 1);
    cmp("clr_same_samples", 32'(sample_count), 0);
    cmp("clr_same_errors", 32'(error_count), 0);
    run = 0; cyc_t(); run = 1;
    cmp("run0_peak_max", 32'(peak_max), 32'h800000);
    cmp("run0_peak_min", 32'(peak_min), 32'h7fffff);
    cmp("run0_locked", 32'(locked), 0);
    cmp("run0_period", 32'(period_clks), 0);
    strobe(DC_POS, DC_POS, 0);
    cmp("idle_strobe_ignored", 32'(sample_count), 0);

    idle(4);
    cmp("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
